// File: rtl/ahb_sub_mem_responder_pkg.sv
// Shared AHB-Lite encodings plus the responder's state type and byte-lane helper.
// Transfer and state enums share this namespace, so transfer literals carry a TRANS_ prefix.
package ahb_sub_mem_responder_pkg;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'b00,
        TRANS_BUSY   = 2'b01,
        TRANS_NONSEQ = 2'b10,
        TRANS_SEQ    = 2'b11
    } ahb_transfer_e;

    typedef enum logic [2:0] {
        SIZE_BYTE     = 3'd0,
        SIZE_HALFWORD = 3'd1,
        SIZE_WORD     = 3'd2,
        SIZE_DWORD    = 3'd3,
        SIZE_4WORD    = 3'd4,
        SIZE_8WORD    = 3'd5,
        SIZE_16WORD   = 3'd6,
        SIZE_32WORD   = 3'd7
    } hsize_e;

    typedef enum logic [2:0] {
        BURST_SINGLE = 3'd0,
        BURST_INCR   = 3'd1,
        BURST_WRAP4  = 3'd2,
        BURST_INCR4  = 3'd3,
        BURST_WRAP8  = 3'd4,
        BURST_INCR8  = 3'd5,
        BURST_WRAP16 = 3'd6,
        BURST_INCR16 = 3'd7
    } ahb_burst_e;

    typedef enum logic {
        OKAY  = 1'b0,
        ERROR = 1'b1
    } ahb_resp_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WAIT = 3'd1,
        LAST = 3'd2,
        ERR1 = 3'd3,
        ERR2 = 3'd4
    } ahb_sub_state_e;

    // Little-endian byte enables; alignment is checked elsewhere.
    function automatic logic [3:0] ahb_lane_mask(hsize_e size, logic [1:0] lane);
        case (size)
            SIZE_BYTE:     return 4'b0001 << lane;
            SIZE_HALFWORD: return lane[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD:     return 4'b1111;
            default:       return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/ahb_sub_byte_ram.sv
// Word-organised RAM with per-byte write enables and a combinational read port.
// Deliberately not reset: contents only change through bus writes.
module ahb_sub_byte_ram #(
    parameter int DEPTH = 256,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic [3:0]       byte_en,
    input  logic [IDX_W-1:0] addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) begin
                mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ahb_sub_mem_responder.sv
// AHB-Lite memory subordinate with programmable wait states and two-cycle ERROR response.
// Outputs decode only registered state, so there is no input-to-output combinational path.
module ahb_sub_mem_responder
    import ahb_sub_mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    input  logic [2:0]            wait_cfg,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [DATA_WIDTH-1:0] HRDATA
);

    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(4 * MEM_DEPTH);

    ahb_sub_state_e state_q, state_d;
    logic [2:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q;
    logic [1:0]     lane_q;
    hsize_e         size_q;
    logic           write_q;

    ahb_transfer_e  trans;
    hsize_e         size_in;
    logic           can_accept;
    logic           accept;
    logic           illegal;
    ahb_resp_e      resp;
    logic [3:0]     byte_en;
    logic [31:0]    ram_rdata;

    // Every beat is decoded from HADDR, so burst type carries no information here.
    logic unused_ok;
    assign unused_ok = &{1'b0, HBURST};

    assign trans      = ahb_transfer_e'(HTRANS);
    assign size_in    = hsize_e'(HSIZE);
    assign can_accept = (state_q == IDLE) || (state_q == LAST) || (state_q == ERR2);
    assign accept     = can_accept && HSEL && HREADY &&
                        ((trans == TRANS_NONSEQ) || (trans == TRANS_SEQ));
    assign illegal    = (HADDR >= ADDR_LIMIT) || (size_in > SIZE_WORD) ||
                        ((size_in == SIZE_HALFWORD) && HADDR[0]) ||
                        ((size_in == SIZE_WORD) && (HADDR[1:0] != 2'b00));

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            idx_q   <= '0;
            lane_q  <= 2'b00;
            size_q  <= SIZE_BYTE;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                idx_q   <= HADDR[IDX_W+1:2];
                lane_q  <= HADDR[1:0];
                size_q  <= size_in;
                write_q <= HWRITE;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q <= 3'd1) begin
                    state_d = LAST;
                end
            end
            ERR1: state_d = ERR2;
            default: begin
                // IDLE, LAST and ERR2 all close a data phase and may start the next one.
                state_d = IDLE;
                if (accept) begin
                    if (illegal) begin
                        state_d = ERR1;
                    end else if (wait_cfg == 3'd0) begin
                        state_d = LAST;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = wait_cfg;
                    end
                end
            end
        endcase
    end

    always_comb begin
        HREADYOUT = 1'b1;
        resp      = OKAY;
        HRDATA    = '0;
        byte_en   = 4'b0000;
        case (state_q)
            WAIT: HREADYOUT = 1'b0;
            LAST: begin
                if (write_q) begin
                    byte_en = ahb_lane_mask(size_q, lane_q);
                end else begin
                    HRDATA = ram_rdata;
                end
            end
            ERR1: begin
                HREADYOUT = 1'b0;
                resp      = ERROR;
            end
            ERR2: resp = ERROR;
            default: ;
        endcase
    end

    assign HRESP = resp;

    ahb_sub_byte_ram #(
        .DEPTH (MEM_DEPTH),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk     (HCLK),
        .byte_en (byte_en),
        .addr    (idx_q),
        .wdata   (HWDATA),
        .rdata   (ram_rdata)
    );

endmodule

// File: tb/tb_ahb_sub_mem_responder.sv
// Directed bench for ahb_sub_mem_responder with hand-computed expectations.
// Inputs are driven 1ns after the rising edge and outputs sampled on the falling edge.
module tb_ahb_sub_mem_responder;

    localparam logic [2:0] SZ_BYTE = 3'd0;
    localparam logic [2:0] SZ_HALF = 3'd1;
    localparam logic [2:0] SZ_WORD = 3'd2;
    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_NONSEQ = 2'b10;

    logic        HCLK;
    logic        HRESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic        hready_bus;
    logic [2:0]  wait_cfg;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;

    logic        hready_force_low;
    int          test_count;
    int          fail_count;
    int          n_cycles;
    logic        ready_hist [16];
    logic        resp_hist  [16];
    logic [31:0] rd_hist    [16];

    assign hready_bus = HREADYOUT & ~hready_force_low;

    ahb_sub_mem_responder dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HBURST    (HBURST),
        .HWDATA    (HWDATA),
        .HREADY    (hready_bus),
        .wait_cfg  (wait_cfg),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        test_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // One complete transfer from an idle bus; records every data-phase cycle.
    task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                                 input logic [31:0] wdata, input logic [2:0] wcfg);
        logic done;
        HSEL     = 1'b1;
        HTRANS   = TR_NONSEQ;
        HADDR    = addr;
        HWRITE   = wr;
        HSIZE    = size;
        wait_cfg = wcfg;
        @(posedge HCLK); #1;
        HTRANS   = TR_IDLE;
        HWDATA   = wdata;
        wait_cfg = 3'd7;
        n_cycles = 0;
        done     = 1'b0;
        while (!done && n_cycles < 16) begin
            @(negedge HCLK);
            ready_hist[n_cycles] = HREADYOUT;
            resp_hist[n_cycles]  = HRESP;
            rd_hist[n_cycles]    = HRDATA;
            n_cycles++;
            done = HREADYOUT;
            @(posedge HCLK); #1;
        end
    endtask

    initial begin
        test_count       = 0;
        fail_count       = 0;
        hready_force_low = 1'b0;
        HRESETn  = 1'b0;
        HSEL     = 1'b0;
        HADDR    = 32'h0;
        HTRANS   = TR_IDLE;
        HWRITE   = 1'b0;
        HSIZE    = SZ_WORD;
        HBURST   = 3'd0;
        HWDATA   = 32'h0;
        wait_cfg = 3'd0;

        repeat (2) @(negedge HCLK);
        checkOutput("rst_hreadyout", {31'd0, HREADYOUT}, 32'h1);
        checkOutput("rst_hresp",     {31'd0, HRESP},     32'h0);
        checkOutput("rst_hrdata",    HRDATA,             32'h0);
        HRESETn = 1'b1;
        @(posedge HCLK); #1;

        // Zero-wait write then read
        applyStimulus(1'b1, 32'h10, SZ_WORD, 32'hDEADBEEF, 3'd0);
        checkOutput("wr0_cycles", n_cycles, 32'd1);
        checkOutput("wr0_resp",   {31'd0, resp_hist[0]}, 32'h0);
        applyStimulus(1'b0, 32'h10, SZ_WORD, 32'h0, 3'd0);
        checkOutput("rd0_cycles", n_cycles, 32'd1);
        checkOutput("rd0_resp",   {31'd0, resp_hist[0]}, 32'h0);
        checkOutput("rd0_data",   rd_hist[0], 32'hDEADBEEF);

        // Three wait states; wait_cfg is disturbed during WAIT by the task
        applyStimulus(1'b0, 32'h10, SZ_WORD, 32'h0, 3'd3);
        checkOutput("rd3_cycles", n_cycles, 32'd4);
        checkOutput("rd3_ready",  {28'd0, ready_hist[0], ready_hist[1], ready_hist[2], ready_hist[3]}, 32'h1);
        checkOutput("rd3_data_w0", rd_hist[0], 32'h0);
        checkOutput("rd3_data_w2", rd_hist[2], 32'h0);
        checkOutput("rd3_data",    rd_hist[3], 32'hDEADBEEF);

        // BUSY with HSEL: zero-wait OKAY, nothing started
        HSEL = 1'b1; HTRANS = TR_BUSY; HADDR = 32'h10; HWRITE = 1'b1; wait_cfg = 3'd3;
        @(posedge HCLK); #1;
        HTRANS = TR_IDLE;
        @(negedge HCLK);
        checkOutput("busy_rdy_resp", {30'd0, HREADYOUT, HRESP}, 32'h2);
        @(posedge HCLK); #1;

        // HREADY low blocks acceptance
        hready_force_low = 1'b1;
        HTRANS = TR_NONSEQ; HADDR = 32'h10; HWRITE = 1'b1; HSIZE = SZ_WORD; wait_cfg = 3'd3;
        @(posedge HCLK); #1;
        hready_force_low = 1'b0;
        HTRANS = TR_IDLE; HWDATA = 32'hFFFFFFFF;
        @(negedge HCLK);
        checkOutput("hready_low_noaccept", {31'd0, HREADYOUT}, 32'h1);
        @(posedge HCLK); #1;

        // Illegal transfers: out of range, misaligned halfword
        applyStimulus(1'b1, 32'h400, SZ_WORD, 32'h12345678, 3'd0);
        checkOutput("err_range_cycles", n_cycles, 32'd2);
        checkOutput("err_range_rdyresp", {28'd0, ready_hist[0], resp_hist[0], ready_hist[1], resp_hist[1]}, 32'h7);
        applyStimulus(1'b1, 32'h11, SZ_HALF, 32'h12345678, 3'd2);
        checkOutput("err_half_cycles", n_cycles, 32'd2);
        checkOutput("err_half_rdyresp", {28'd0, ready_hist[0], resp_hist[0], ready_hist[1], resp_hist[1]}, 32'h7);
        applyStimulus(1'b0, 32'h10, SZ_WORD, 32'h0, 3'd0);
        checkOutput("rd_unchanged", rd_hist[0], 32'hDEADBEEF);

        // Byte and halfword lane writes
        applyStimulus(1'b1, 32'h10, SZ_WORD, 32'h11223344, 3'd0);
        applyStimulus(1'b1, 32'h13, SZ_BYTE, 32'hAA000000, 3'd1);
        applyStimulus(1'b0, 32'h10, SZ_WORD, 32'h0, 3'd0);
        checkOutput("byte_lane", rd_hist[0], 32'hAA223344);
        applyStimulus(1'b1, 32'h10, SZ_HALF, 32'h0000BEEF, 3'd0);
        applyStimulus(1'b0, 32'h10, SZ_WORD, 32'h0, 3'd2);
        checkOutput("half_lane", rd_hist[2], 32'hAA22BEEF);

        // Pipelined write then read to the same word
        HSEL = 1'b1; HTRANS = TR_NONSEQ; HADDR = 32'h20; HWRITE = 1'b1; HSIZE = SZ_WORD; wait_cfg = 3'd0;
        @(posedge HCLK); #1;
        HWDATA = 32'h55AA55AA; HWRITE = 1'b0;
        @(negedge HCLK);
        checkOutput("pipe_wr_ready", {31'd0, HREADYOUT}, 32'h1);
        @(posedge HCLK); #1;
        HTRANS = TR_IDLE;
        @(negedge HCLK);
        checkOutput("pipe_rd_ready", {31'd0, HREADYOUT}, 32'h1);
        checkOutput("pipe_rd_data",  HRDATA, 32'h55AA55AA);
        @(posedge HCLK); #1;

        // Reset during WAIT abandons the write
        applyStimulus(1'b1, 32'h30, SZ_WORD, 32'hCAFEF00D, 3'd0);
        HTRANS = TR_NONSEQ; HADDR = 32'h30; HWRITE = 1'b1; HSIZE = SZ_WORD; wait_cfg = 3'd5;
        @(posedge HCLK); #1;
        HTRANS = TR_IDLE; HWDATA = 32'h00000001;
        @(posedge HCLK); #1;
        checkOutput("rst_wait_before", {31'd0, HREADYOUT}, 32'h0);
        HRESETn = 1'b0;
        #1;
        checkOutput("rst_async_ready", {31'd0, HREADYOUT}, 32'h1);
        checkOutput("rst_async_resp",  {31'd0, HRESP},     32'h0);
        checkOutput("rst_async_rdata", HRDATA,             32'h0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
        applyStimulus(1'b0, 32'h30, SZ_WORD, 32'h0, 3'd0);
        checkOutput("rst_no_commit", rd_hist[0], 32'hCAFEF00D);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
